// File: rtl/multipli_arb_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and pointer sizing.
package multipli_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_REQ_DEF = 4;
    localparam int PTR_W     = ptr_w(N_REQ_DEF);

endpackage

// File: rtl/multipli_arb_if.sv
// Requester-side and multiplier-side signals of the arbiter; master is the arbiter.
interface multipli_arb_if #(
    parameter int N_REQ = 4,
    parameter int size  = 8
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ*size-1:0] A_in;
    logic [N_REQ*size-1:0] B_in;
    logic [N_REQ-1:0]      ack;
    logic [N_REQ-1:0]      done;
    logic [2*size-1:0]     S_out;
    logic                  err;
    logic [size-1:0]       mult_A;
    logic [size-1:0]       mult_B;
    logic                  mult_start;
    logic                  mult_fin;
    logic [2*size-1:0]     mult_S;

    modport master (
        input  req, A_in, B_in, mult_fin, mult_S,
        output ack, done, S_out, err, mult_A, mult_B, mult_start
    );

    modport slave (
        output req, A_in, B_in, mult_fin, mult_S,
        input  ack, done, S_out, err, mult_A, mult_B, mult_start
    );
endinterface

// File: rtl/multipli_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module multipli_arb_rr_pick
    import multipli_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [N_REQ-1:0] grant
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/multipli_arbiter.sv
// Round-robin share of one sequential multiplier among N_REQ requesters.
// Optional run watchdog enabled by defining MULTIPLI_ARB_TIMEOUT_EN.
module multipli_arbiter
    import multipli_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int size           = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic           CLK,
    input logic           RESET,
    multipli_arb_if.master bus
);
    localparam int PW = ptr_w(N_REQ);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     g_q, g_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [2*size-1:0] s_q, s_d;
    logic [size-1:0]   ma_q, ma_d;
    logic [size-1:0]   mb_q, mb_d;
    logic              start_q, start_d;

    logic              any;
    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     ptr_nxt;

`ifdef MULTIPLI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    multipli_arb_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .any   (any),
        .grant (grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    // Pointer moves just past the requester that was served.
    assign ptr_nxt = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        ack_d   = '0;
        done_d  = '0;
        s_d     = s_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        start_d = 1'b0;
`ifdef MULTIPLI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = START;
                    g_d     = gidx;
                    ack_d   = grant;
                    ma_d    = bus.A_in[gidx*size +: size];
                    mb_d    = bus.B_in[gidx*size +: size];
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef MULTIPLI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.mult_fin) begin
                    state_d = IDLE;
                    s_d     = bus.mult_S;
                    done_d  = N_REQ'(1) << g_q;
                    ptr_d   = ptr_nxt;
                end
`ifdef MULTIPLI_ARB_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles; this edge is the limit-th.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    s_d     = '0;
                    done_d  = N_REQ'(1) << g_q;
                    err_d   = 1'b1;
                    ptr_d   = ptr_nxt;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            s_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            start_q <= 1'b0;
`ifdef MULTIPLI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            s_q     <= s_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            start_q <= start_d;
`ifdef MULTIPLI_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.ack        = ack_q;
    assign bus.done       = done_q;
    assign bus.S_out      = s_q;
    assign bus.mult_A     = ma_q;
    assign bus.mult_B     = mb_q;
    assign bus.mult_start = start_q;
`ifdef MULTIPLI_ARB_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_multipli_arbiter.sv
// Randomized bench: transaction-level requester/multiplier model with round-robin grant prediction.
module tb_multipli_arbiter;
    localparam int N   = 4;
    localparam int SZ  = 8;
    localparam int TMO = 64;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    multipli_arb_if #(.N_REQ(N), .size(SZ)) bus();

    multipli_arbiter #(.N_REQ(N), .size(SZ), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state
    logic [N-1:0]  req_r;
    logic [SZ-1:0] a_r[N], b_r[N];
    logic [SZ-1:0] pa, pb, last_a, last_b;
    logic [15:0]   prod_m, last_s;
    bit auto_rr, rand_req, no_fin, busy, exp_err;
    int ptr_m, g_m, pred_ack, pred_done, mcnt, tcnt, lat_lo, lat_hi;
    int gq[$];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    task automatic drive();
        bus.req = req_r;
        for (int i = 0; i < N; i++) begin
            bus.A_in[i*SZ +: SZ] = a_r[i];
            bus.B_in[i*SZ +: SZ] = b_r[i];
        end
    endtask

    task automatic step();
        @(negedge CLK);
        chk("ack", bus.ack, (pred_ack >= 0) ? (32'd1 << pred_ack) : 32'd0);
        chk("start", bus.mult_start, pred_ack >= 0);
        if (pred_ack >= 0) begin
            last_a = pa; last_b = pb;
            gq.push_back(pred_ack);
        end
        chk("multA", bus.mult_A, last_a);
        chk("multB", bus.mult_B, last_b);
        chk("done", bus.done, (pred_done >= 0) ? (32'd1 << pred_done) : 32'd0);
        chk("err", bus.err, (pred_done >= 0) && exp_err);
        if (pred_done >= 0) last_s = exp_err ? 16'd0 : prod_m;
        chk("S_out", bus.S_out, last_s);

        if (pred_ack >= 0) begin
            req_r[pred_ack] = 1'b0;
            if (no_fin) tcnt = TMO + 1;
            else        mcnt = $urandom_range(lat_hi, lat_lo);
        end
        if (pred_done >= 0) begin
            busy  = 0;
            ptr_m = (pred_done + 1) % N;
        end
        pred_ack = -1; pred_done = -1; exp_err = 0;

        // Multiplier: garbage on mult_S except at fin; spurious fin only while idle.
        bus.mult_fin = 1'b0;
        bus.mult_S   = 16'($urandom);
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                bus.mult_fin = 1'b1;
                bus.mult_S   = prod_m;
                pred_done    = g_m;
            end
        end else if (!busy && $urandom_range(3, 0) == 0) begin
            bus.mult_fin = 1'b1;
        end
        if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) begin
                pred_done = g_m;
                exp_err   = 1;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (!req_r[i] && (auto_rr || (rand_req && $urandom_range(3, 0) == 0))) begin
                req_r[i] = 1'b1;
                a_r[i]   = 8'($urandom);
                b_r[i]   = 8'($urandom);
            end
        end

        if (!busy && req_r != '0) begin
            pred_ack = pick(req_r, ptr_m);
            g_m      = pred_ack;
            busy     = 1;
            pa       = a_r[g_m];
            pb       = b_r[g_m];
            prod_m   = smul(pa, pb);
        end
        drive();
    endtask

    task automatic wait_quiet(input int max);
        int n = 0;
        while ((busy || req_r != '0 || pred_ack >= 0) && n < max) begin
            step();
            n++;
        end
        chk("drain", n < max, 1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        req_r = '0;
        drive();
        bus.mult_fin = 1'b0;
        busy = 0; ptr_m = 0; pred_ack = -1; pred_done = -1;
        mcnt = 0; tcnt = 0; exp_err = 0;
        last_a = '0; last_b = '0; last_s = '0;
        #1;
        chk("rst_ack", bus.ack, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_S", bus.S_out, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mA", bus.mult_A, 0);
        chk("rst_mB", bus.mult_B, 0);
        chk("rst_start", bus.mult_start, 0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] p;
        auto_rr = 0; rand_req = 0; no_fin = 0;
        lat_lo = 2; lat_hi = 7;
        for (int i = 0; i < N; i++) begin a_r[i] = '0; b_r[i] = '0; end
        bus.mult_fin = 1'b0;
        bus.mult_S   = '0;
        #1;
        do_reset();

        // Single request
        a_r[0] = 8'd45; b_r[0] = 8'd96; req_r = 4'b0001;
        wait_quiet(50);
        chk("single_S", bus.S_out, 16'd4320);
        chk("single_g", (gq.size() > 0) ? gq[0] : -1, 0);

        // Signed operands
        a_r[2] = 8'hD3; b_r[2] = 8'hA0; req_r = 4'b0100;
        wait_quiet(50);
        chk("neg_neg", bus.S_out, 16'd4320);
        a_r[2] = 8'hD3; b_r[2] = 8'd96; req_r = 4'b0100;
        wait_quiet(50);
        chk("neg_pos", bus.S_out, 16'hEF20);

        // Contention from reset
        do_reset();
        gq.delete();
        for (int i = 0; i < N; i++) begin a_r[i] = 8'(10 + i); b_r[i] = 8'(250 - 7 * i); end
        req_r = '1;
        auto_rr = 1;
        n = 0;
        while (gq.size() < 5 && n < 200) begin step(); n++; end
        auto_rr = 0;
        wait_quiet(200);
        chk("cont_n", gq.size() >= 5, 1);
        for (int i = 0; i < 5; i++) chk("cont_order", (i < gq.size()) ? gq[i] : -1, i % N);

        // Wrap-around: after 3 is served, 1 beats 3
        do_reset();
        gq.delete();
        req_r = 4'b1000;
        wait_quiet(50);
        req_r = 4'b1010;
        wait_quiet(100);
        chk("wrap_n", gq.size(), 3);
        chk("wrap_1st", (gq.size() > 1) ? gq[1] : -1, 1);
        chk("wrap_2nd", (gq.size() > 2) ? gq[2] : -1, 3);

        // Reset while the multiplier is running
        gq.delete();
        lat_lo = 20; lat_hi = 30;
        a_r[1] = 8'd7; b_r[1] = 8'hF9; req_r = 4'b0010;
        n = 0;
        while (gq.size() == 0 && n < 20) begin step(); n++; end
        chk("rw_ack", gq.size(), 1);
        step(); step();
        do_reset();
        repeat (4) step();
        lat_lo = 2; lat_hi = 7;
        gq.delete();
        a_r[1] = 8'd100; b_r[1] = 8'hCE; req_r = 4'b0010;
        wait_quiet(50);
        p = smul(8'd100, 8'hCE);
        chk("rw_redo_g", (gq.size() > 0) ? gq[0] : -1, 1);
        chk("rw_redo_S", bus.S_out, p);

        // Random traffic
        rand_req = 1;
        repeat (600) step();
        rand_req = 0;
        wait_quiet(300);

`ifdef MULTIPLI_ARB_TIMEOUT_EN
        no_fin = 1;
        a_r[3] = 8'd12; b_r[3] = 8'd13; req_r = 4'b1000;
        wait_quiet(TMO + 20);
        chk("tmo_S", bus.S_out, 0);
        no_fin = 0;
        a_r[0] = 8'd3; b_r[0] = 8'd5; req_r = 4'b0001;
        wait_quiet(50);
        chk("tmo_after", bus.S_out, 16'd15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
